hash_stream_ctrl: RTL and testbench

//  Initiator side of the light-hash start/done interface. Accepts a byte stream with a last flag and packs it into 4-byte blocks.

---
 rtl/hash_light_pkg.sv | 39 +++
 rtl/hash_byte_packer.sv | 76 +++++++
 rtl/hash_stream_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_hash_stream_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hash_light_pkg.sv
// hash_light_pkg
//   Shared types and constants for the light-hash streaming front end.
//   byte_t  : one message byte
//   block_t : four message bytes, element 0 is the first byte and sits in bits [31:24]
//   PAD_BYTE: marker byte appended directly after the final message byte
//   ctrl_state_e: controller states FILL / START / WAIT / OUT
//   pad_tail(): builds the closing block of a message that ends inside a block
package hash_light_pkg;

  typedef logic [7:0] byte_t;
  typedef byte_t [0:3] block_t;

  localparam byte_t PAD_BYTE = 8'h80;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } ctrl_state_e;

  // Place the final byte at slot k, the pad marker at k+1 and zeros after it.
  function automatic block_t pad_tail(input block_t blk, input logic [1:0] k, input byte_t data);
    block_t res;
    res    = blk;
    res[k] = data;
    for (int j = 0; j < 4; j++) begin
      if (j == int'(k) + 1) begin
        res[j] = PAD_BYTE;
      end else if (j > int'(k) + 1) begin
        res[j] = 8'h00;
      end else begin
        res[j] = res[j];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/hash_byte_packer.sv
// hash_byte_packer
//   Collects accepted message bytes into a 4-byte block, inserts the tail
//   padding and tracks whether the current block is the last one of the
//   message or whether an extra all-padding block still has to follow.
// Ports
//   clk, rst_n   : clock, async active-low reset
//   accept       : a byte is taken this cycle (already qualified by the controller)
//   data, last   : the byte and its end-of-message flag
//   load_pad     : replace the block with the stand-alone pad block {80,00,00,00}
//   clr          : drop the partial block and both flags
//   blk          : current block contents (held stable while the core works on it)
//   idx          : next free slot in the block
//   blk_done     : the accepted byte closes the block (combinational)
//   pad_pending  : message ended exactly on a block boundary, pad block still owed
//   last_blk     : current block is the final block of the message
module hash_byte_packer
  import hash_light_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       accept,
  input  byte_t      data,
  input  logic       last,
  input  logic       load_pad,
  input  logic       clr,
  output block_t     blk,
  output logic [1:0] idx,
  output logic       blk_done,
  output logic       pad_pending,
  output logic       last_blk
);

  block_t     buf_r;
  logic [1:0] idx_r;
  logic       pad_pending_r;
  logic       last_blk_r;

  assign blk         = buf_r;
  assign idx         = idx_r;
  assign pad_pending = pad_pending_r;
  assign last_blk    = last_blk_r;

  // A block closes on its fourth byte or on the message's final byte.
  assign blk_done = accept && (last || (idx_r == 2'd3));

  // Byte capture, tail padding and last/pad flag tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_r         <= '0;
      idx_r         <= 2'd0;
      pad_pending_r <= 1'b0;
      last_blk_r    <= 1'b0;
    end else if (clr) begin
      idx_r         <= 2'd0;
      pad_pending_r <= 1'b0;
      last_blk_r    <= 1'b0;
    end else if (load_pad) begin
      buf_r         <= {PAD_BYTE, 8'h00, 8'h00, 8'h00};
      pad_pending_r <= 1'b0;
      last_blk_r    <= 1'b1;
    end else if (accept) begin
      if (last && (idx_r != 2'd3)) begin
        // Message ends inside the block: pad in place, this is the final block.
        buf_r      <= pad_tail(buf_r, idx_r, data);
        idx_r      <= 2'd0;
        last_blk_r <= 1'b1;
      end else begin
        // idx wraps 3 -> 0 when the block fills up.
        buf_r[idx_r]  <= data;
        idx_r         <= idx_r + 2'd1;
        pad_pending_r <= last && (idx_r == 2'd3);
      end
    end
  end

endmodule

// File: rtl/hash_stream_ctrl.sv
// hash_stream_ctrl
//   Initiator side of the light-hash start/done interface. Packs a byte stream
//   into padded 4-byte blocks, runs the external hash core once per block with
//   the previous digest as chaining value, and presents the final digest on a
//   valid/ready port. A core that stays silent for TIMEOUT_CYC cycles after a
//   start pulse aborts the message with a one-cycle err pulse.
// Parameters
//   IV0         : initial chaining value (byte 0 = IV0[31:24])
//   TIMEOUT_CYC : cycles after hc_start at which a missing hc_done aborts
// Ports
//   s_valid/s_ready/s_data/s_last : byte stream in
//   hc_start/hc_m/hc_iv           : block request to the core
//   hc_d/hc_done                  : core result
//   dig_valid/dig_ready/dig       : final digest out
//   busy                          : low only when idle in FILL with an empty block
//   err                           : one-cycle core timeout pulse
// Optional build macro HASH_STREAM_VERIFY_EN adds exp_dig (reference digest,
// sampled at the start of the last block) and match (final digest == exp_dig,
// valid alongside dig_valid).
module hash_stream_ctrl
  import hash_light_pkg::*;
#(
  parameter block_t IV0         = 32'h0123_4567,
  parameter int     TIMEOUT_CYC = 64
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   s_valid,
  output logic   s_ready,
  input  byte_t  s_data,
  input  logic   s_last,
  output logic   hc_start,
  output block_t hc_m,
  output block_t hc_iv,
  input  block_t hc_d,
  input  logic   hc_done,
  output logic   dig_valid,
  input  logic   dig_ready,
  output block_t dig,
  output logic   busy,
  output logic   err
`ifdef HASH_STREAM_VERIFY_EN
  ,
  input  block_t exp_dig,
  output logic   match
`endif
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

  ctrl_state_e state_r, next_state_s;

  block_t        chain_r;
  block_t        dig_r;
  logic [TW-1:0] timer_r;
  logic          s_ready_r, hc_start_r, dig_valid_r, err_r;

  logic          s_ready_nx_s, hc_start_nx_s, dig_valid_nx_s, err_nx_s;
  logic          done_s, timeout_s, handshake_s, load_pad_s, clr_s;
  logic          accept_s;

  block_t        blk_s;
  logic [1:0]    idx_s;
  logic          blk_done_s, pad_pending_s, last_blk_s;

  assign accept_s = s_valid && s_ready_r;

  hash_byte_packer u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .accept      (accept_s),
    .data        (s_data),
    .last        (s_last),
    .load_pad    (load_pad_s),
    .clr         (clr_s),
    .blk         (blk_s),
    .idx         (idx_s),
    .blk_done    (blk_done_s),
    .pad_pending (pad_pending_s),
    .last_blk    (last_blk_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= FILL;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode; hc_done only counts while waiting on the core
  always_comb begin
    next_state_s = state_r;
    done_s       = 1'b0;
    timeout_s    = 1'b0;
    handshake_s  = 1'b0;
    case (state_r)
      FILL: begin
        if (blk_done_s) begin
          next_state_s = START;
        end else begin
          next_state_s = FILL;
        end
      end
      START: begin
        next_state_s = WAIT;
      end
      WAIT: begin
        if (hc_done) begin
          done_s = 1'b1;
          if (last_blk_s) begin
            next_state_s = OUT;
          end else if (pad_pending_s) begin
            next_state_s = START;
          end else begin
            next_state_s = FILL;
          end
        end else if (timer_r == TIMER_LAST) begin
          timeout_s    = 1'b1;
          next_state_s = FILL;
        end else begin
          next_state_s = WAIT;
        end
      end
      OUT: begin
        // dig_valid is high for the whole of OUT, so dig_ready alone completes it.
        if (dig_ready) begin
          handshake_s  = 1'b1;
          next_state_s = FILL;
        end else begin
          next_state_s = OUT;
        end
      end
      default: begin
        next_state_s = FILL;
      end
    endcase
  end

  // Output decode; handshake outputs are registered from the next state
  always_comb begin
    load_pad_s     = done_s && !last_blk_s && pad_pending_s;
    clr_s          = timeout_s || handshake_s;
    s_ready_nx_s   = (next_state_s == FILL);
    hc_start_nx_s  = (next_state_s == START);
    dig_valid_nx_s = (next_state_s == OUT);
    err_nx_s       = timeout_s;
  end

  // Registered handshake / status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready_r   <= 1'b0;
      hc_start_r  <= 1'b0;
      dig_valid_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      s_ready_r   <= s_ready_nx_s;
      hc_start_r  <= hc_start_nx_s;
      dig_valid_r <= dig_valid_nx_s;
      err_r       <= err_nx_s;
    end
  end

  // Chaining value, core watchdog and final digest
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_r <= IV0;
      timer_r <= '0;
      dig_r   <= '0;
    end else begin
      // timer holds the number of cycles elapsed since the start pulse
      if (state_r == START) begin
        timer_r <= TIMER_ONE;
      end else if (state_r == WAIT) begin
        timer_r <= timer_r + TIMER_ONE;
      end else begin
        timer_r <= timer_r;
      end
      if (done_s) begin
        chain_r <= hc_d;
      end else if (clr_s) begin
        chain_r <= IV0;
      end else begin
        chain_r <= chain_r;
      end
      if (done_s && last_blk_s) begin
        dig_r <= hc_d;
      end else begin
        dig_r <= dig_r;
      end
    end
  end

`ifdef HASH_STREAM_VERIFY_EN
  block_t exp_r;
  logic   match_r;

  // Reference captured with the last block's start, compared as the digest lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_r   <= '0;
      match_r <= 1'b0;
    end else begin
      if ((state_r == START) && last_blk_s) begin
        exp_r <= exp_dig;
      end else begin
        exp_r <= exp_r;
      end
      if (done_s && last_blk_s) begin
        match_r <= (hc_d == exp_r);
      end else begin
        match_r <= match_r;
      end
    end
  end

  assign match = match_r;
`endif

  // Block and chaining value come straight from registers that only change
  // outside START/WAIT, which keeps them stable for the whole core pass.
  assign s_ready   = s_ready_r;
  assign hc_start  = hc_start_r;
  assign hc_m      = blk_s;
  assign hc_iv     = chain_r;
  assign dig_valid = dig_valid_r;
  assign dig       = dig_r;
  assign err       = err_r;
  assign busy      = !((state_r == FILL) && (idx_s == 2'd0));

endmodule

// File: tb/tb_hash_stream_ctrl.sv
`timescale 1ns/1ps
// Bench for hash_stream_ctrl: a behavioural hash core, a message-level golden
// model (pad, split into blocks, chain from IV0) and one compare process.
module tb_hash_stream_ctrl;
  import hash_light_pkg::*;

  localparam logic [31:0] IV0      = 32'h0123_4567;
  localparam int          TO       = 64;
  localparam int          CORE_LAT = 27;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        hc_done = 1'b0;
  logic        dig_ready = 1'b1;
  block_t      hc_d = '0;
  logic        s_ready, hc_start, dig_valid, busy, err;
  block_t      hc_m, hc_iv, dig;
`ifdef HASH_STREAM_VERIFY_EN
  block_t      exp_dig = '0;
  logic        match;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  hash_stream_ctrl #(.IV0(IV0), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .hc_start(hc_start), .hc_m(hc_m), .hc_iv(hc_iv), .hc_d(hc_d), .hc_done(hc_done),
    .dig_valid(dig_valid), .dig_ready(dig_ready), .dig(dig),
    .busy(busy), .err(err)
`ifdef HASH_STREAM_VERIFY_EN
    , .exp_dig(exp_dig), .match(match)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Core transform shared by the core model and the golden model.
  function automatic logic [31:0] core_f(input logic [31:0] m, input logic [31:0] iv);
    return (m ^ {iv[23:0], iv[31:24]}) + 32'h9E37_79B9;
  endfunction

  // ---------------- golden model ----------------
  logic [7:0]  msg_q[$];
  logic [31:0] exp_m_q[$], exp_iv_q[$], exp_dg_q[$];
  logic        exp_match_q[$];
  logic [31:0] flip_mask = 32'h0;

  task automatic model_push();
    logic [7:0]  p[$];
    logic [31:0] ch, blk;
    p = msg_q;
    p.push_back(8'h80);
    while (p.size() % 4 != 0) p.push_back(8'h00);
    ch = IV0;
    for (int i = 0; i < p.size(); i += 4) begin
      blk = {p[i], p[i+1], p[i+2], p[i+3]};
      exp_m_q.push_back(blk);
      exp_iv_q.push_back(ch);
      ch = core_f(blk, ch);
    end
    exp_dg_q.push_back(ch);
    exp_match_q.push_back(flip_mask == 32'h0);
`ifdef HASH_STREAM_VERIFY_EN
    exp_dig = ch ^ flip_mask;
`endif
  endtask

  // ---------------- hash core model ----------------
  int          core_cnt = 0;
  logic        core_en = 1'b1;
  logic        core_stale = 1'b0;
  logic [31:0] core_m = 32'h0, core_iv = 32'h0;
  logic [31:0] done_log[$];
  int          done_cyc = -100;

  always @(negedge clk) begin
    hc_done = 1'b0;
    if (hc_start && core_en) begin
      core_m     = hc_m;
      core_iv    = hc_iv;
      core_cnt   = CORE_LAT;
      core_stale = 1'b0;
    end else if (core_cnt > 0) begin
      if (!core_stale) begin
        chk("hc_m_stable", hc_m, core_m);
        chk("hc_iv_stable", hc_iv, core_iv);
      end
      core_cnt--;
      if (core_cnt == 0) begin
        hc_done  = 1'b1;
        hc_d     = core_f(core_m, core_iv);
        done_cyc = cyc;
        done_log.push_back(hc_d);
      end
    end
  end

  // ---------------- compare process ----------------
  logic [31:0] start_m_log[$], start_iv_log[$];
  int          start_cyc = 0;
  int          err_cnt = 0;
  logic        err_allowed = 1'b0;
  logic        dv_prev = 1'b0, err_prev = 1'b0, hs_prev = 1'b0;
  logic [31:0] dig_prev = 32'h0, last_dig = 32'h0;
  logic        em;

  always @(negedge clk) begin
    if (rst_n) begin
      if (hs_prev) chk("hc_start_width", hc_start, 1'b0);
      if (hc_start) begin
        start_cyc = cyc;
        start_m_log.push_back(hc_m);
        start_iv_log.push_back(hc_iv);
        if (exp_m_q.size() == 0) begin
          fail_now("unexpected_start", $sformatf("hc_m %h with no block expected", hc_m));
        end else begin
          chk("hc_m", hc_m, exp_m_q.pop_front());
          chk("hc_iv", hc_iv, exp_iv_q.pop_front());
        end
      end
      if (dig_valid && !dv_prev) begin
        last_dig = dig;
        if (exp_dg_q.size() == 0) begin
          fail_now("unexpected_dig", $sformatf("dig %h with no digest expected", dig));
        end else begin
          chk("dig", dig, exp_dg_q.pop_front());
          em = (exp_match_q.size() > 0) ? exp_match_q.pop_front() : 1'b1;
`ifdef HASH_STREAM_VERIFY_EN
          chk("match", {31'b0, match}, {31'b0, em});
`endif
        end
        chk("dig_latency", cyc - done_cyc, 32'd1);
      end
      if (dig_valid && dv_prev) begin
        chk("dig_hold", dig, dig_prev);
        chk("s_ready_in_out", s_ready, 1'b0);
      end
      if (err) begin
        err_cnt++;
        chk("err_allowed", err_allowed, 1'b1);
        chk("err_delay", cyc - start_cyc, TO);
      end
      if (err_prev) begin
        chk("err_width", err, 1'b0);
        chk("s_ready_after_err", s_ready, 1'b1);
      end
    end
    dv_prev  = dig_valid & rst_n;
    err_prev = err & rst_n;
    hs_prev  = hc_start & rst_n;
    dig_prev = dig;
  end

  // ---------------- stimulus ----------------
  task automatic clear_logs();
    start_m_log.delete();
    start_iv_log.delete();
    done_log.delete();
  endtask

  task automatic send_msg();
    int n;
    model_push();
    for (int i = 0; i < msg_q.size(); i++) begin
      s_valid = 1'b1;
      s_data  = msg_q[i];
      s_last  = (i == msg_q.size() - 1);
      n = 0;
      while (!s_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (!s_ready) fail_now("s_ready_wait", $sformatf("byte %0d never accepted", i));
      @(negedge clk);
      if (i == 0 && msg_q.size() > 1) chk("busy_mid_block", busy, 1'b1);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_dig(input int hold);
    int n;
    n = 0;
    while (!dig_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!dig_valid) begin
      fail_now("dig_wait", "dig_valid never rose");
    end else begin
      if (hold > 0) begin
        repeat (hold) @(negedge clk);
        chk("dig_valid_held", dig_valid, 1'b1);
        dig_ready = 1'b1;
      end
      @(negedge clk);
      chk("dig_valid_drop", dig_valid, 1'b0);
      chk("idle_busy", busy, 1'b0);
      chk("idle_s_ready", s_ready, 1'b1);
    end
  endtask

  initial begin
    int n;
    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_hc_start", hc_start, 1'b0);
    chk("rst_dig_valid", dig_valid, 1'b0);
    chk("rst_dig", dig, 32'h0);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_s_ready", s_ready, 1'b1);

    // Three bytes: one block padded in place
    clear_logs();
    msg_q = '{8'h11, 8'h22, 8'h33};
    send_msg();
    wait_dig(0);
    chk("t1_starts", start_m_log.size(), 32'd1);
    chk("t1_m_lit", start_m_log[0], 32'h1122_3380);
    chk("t1_iv_lit", start_iv_log[0], 32'h0123_4567);
    chk("t1_dig_lit", last_dig, 32'hD09E_CE3A);

    // Four bytes: extra all-pad block chained on the first digest
    clear_logs();
    msg_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_msg();
    wait_dig(0);
    chk("t2_starts", start_m_log.size(), 32'd2);
    chk("t2_m1_lit", start_m_log[1], 32'h8000_0000);
    chk("t2_d0_lit", done_log[0], 32'hC07E_DDBE);
    chk("t2_iv1_chain", start_iv_log[1], done_log[0]);

    // Five bytes: second block carries the tail byte and the pad marker
    clear_logs();
    msg_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_msg();
    wait_dig(0);
    chk("t3_m0_lit", start_m_log[0], 32'h0102_0304);
    chk("t3_m1_lit", start_m_log[1], 32'h0580_0000);

    // Consumer stalls 10 cycles in OUT; next message restarts from IV0
    dig_ready = 1'b0;
    msg_q = '{8'hC3, 8'h3C};
    send_msg();
    wait_dig(10);
    clear_logs();
    msg_q = '{8'h5E};
    send_msg();
    wait_dig(0);
    chk("t4_iv_restart", start_iv_log[0], 32'h0123_4567);

    // Silent core: timeout abort
    core_en = 1'b0;
    err_allowed = 1'b1;
    err_cnt = 0;
    msg_q = '{8'h5A};
    send_msg();
    n = 0;
    while (err_cnt == 0 && n < 150) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("t5_err_count", err_cnt, 32'd1);
    chk("t5_busy", busy, 1'b0);
    chk("t5_no_dig", dig_valid, 1'b0);
    exp_dg_q.delete();
    exp_match_q.delete();
    err_allowed = 1'b0;
    core_en = 1'b1;

    // Reset while the core is working; its late done lands in FILL
    clear_logs();
    msg_q = '{8'h77};
    send_msg();
    n = 0;
    while (start_m_log.size() == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (start_m_log.size() == 0) fail_now("t6_start_wait", "no hc_start seen");
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    core_stale = 1'b1;
    exp_m_q.delete();
    exp_iv_q.delete();
    exp_dg_q.delete();
    exp_match_q.delete();
    @(negedge clk);
    chk("t6_rst_s_ready", s_ready, 1'b0);
    chk("t6_rst_hc_start", hc_start, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_dig", dig, 32'h0);
    rst_n = 1'b1;
    repeat (35) @(negedge clk);
    chk("t6_idle_s_ready", s_ready, 1'b1);
    chk("t6_idle_dig_valid", dig_valid, 1'b0);
    clear_logs();
    msg_q = '{8'hAA};
    send_msg();
    wait_dig(0);
    chk("t6_m_lit", start_m_log[0], 32'hAA80_0000);
    chk("t6_iv_lit", start_iv_log[0], 32'h0123_4567);

    // Wrong reference digest: match must drop
    flip_mask = 32'h0000_0100;
    msg_q = '{8'hAA};
    send_msg();
    wait_dig(0);
    flip_mask = 32'h0;

    chk("leftover_blocks", exp_m_q.size(), 32'd0);
    chk("leftover_digests", exp_dg_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

endmodule
